// File: rtl/cart_pkg.sv
// Shared definitions for the cartridge loader: controller states and the role
// each fetched flash word plays within a slot image.
package cart_pkg;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_RESTART,
        ST_SETTLE,
        ST_READY,
        ST_ERROR
    } state_t;

    // Slot layout: image words first, then one flags word, then an optional checksum word.
    typedef enum logic [1:0] {
        ROLE_IMAGE,
        ROLE_FLAGS,
        ROLE_CHECK
    } word_role_t;

    function automatic word_role_t word_role(input int unsigned ctr,
                                             input int unsigned image_words);
        if (ctr < image_words) begin
            return ROLE_IMAGE;
        end else if (ctr == image_words) begin
            return ROLE_FLAGS;
        end else begin
            return ROLE_CHECK;
        end
    endfunction

endpackage

// File: rtl/cart_loader.sv
// Copies one cartridge slot from flash into the image RAM, captures the mapper
// flags, optionally verifies a wrapping-sum checksum, then settles before ready.
module cart_loader
    import cart_pkg::*;
#(
    parameter int          IMAGE_WORDS   = 32768,
    parameter int          INDEX_BITS    = 4,
    parameter logic [23:0] BASE_ADDR     = 24'h100000,
    parameter int          SLOT_SHIFT    = 18,
    parameter int          SETTLE_CYCLES = 255,
    parameter int          CHECK_EN      = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           reload,
    input  logic [INDEX_BITS-1:0]          index,
    output logic                           fl_valid,
    output logic [23:0]                    fl_addr,
    input  logic                           fl_ready,
    input  logic [31:0]                    fl_rdata,
    output logic                           mem_wren,
    output logic [$clog2(IMAGE_WORDS)-1:0] mem_addr,
    output logic [31:0]                    mem_wdata,
    output logic [3:0]                     mem_mask,
    output logic                           busy,
    output logic                           cart_ready,
    output logic                           load_error,
    output logic [31:0]                    flags_out
);

    localparam int ADDR_W      = $clog2(IMAGE_WORDS);
    localparam int CTR_W       = $clog2(IMAGE_WORDS + 2);
    localparam int SETTLE_W    = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    // A zero-length settle still spends the single SETTLE cycle before READY.
    localparam int SETTLE_LAST = (SETTLE_CYCLES < 1) ? 0 : SETTLE_CYCLES - 1;

    state_t                  state;
    state_t                  state_next;
    logic [CTR_W-1:0]        word_ctr;
    logic [31:0]             checksum;
    logic [INDEX_BITS-1:0]   index_q;
    logic [SETTLE_W-1:0]     settle_ctr;
    word_role_t              role;
    logic                    accept;
    logic                    sum_ok;
    logic                    settle_done;

    // reload takes priority over a completing read in the same cycle.
    assign accept      = (state == ST_LOAD) && fl_ready && !reload;
    assign role        = word_role(32'(word_ctr), IMAGE_WORDS);
    assign sum_ok      = (fl_rdata == checksum);
    assign settle_done = (settle_ctr == SETTLE_W'(SETTLE_LAST));

    assign fl_addr = BASE_ADDR
                   + 24'(32'(index_q) << SLOT_SHIFT)
                   + 24'(32'(word_ctr) << 2);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_RESTART;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        fl_valid   = 1'b0;
        busy       = 1'b0;
        cart_ready = 1'b0;
        load_error = 1'b0;
        case (state)
            ST_LOAD: begin
                fl_valid = 1'b1;
                busy     = 1'b1;
                if (accept) begin
                    case (role)
                        ROLE_FLAGS: if (CHECK_EN == 0) state_next = ST_SETTLE;
                        ROLE_CHECK: state_next = sum_ok ? ST_SETTLE : ST_ERROR;
                        default:    state_next = ST_LOAD;
                    endcase
                end
            end
            ST_RESTART: begin
                busy       = 1'b1;
                state_next = ST_LOAD;
            end
            ST_SETTLE: begin
                busy = 1'b1;
                if (settle_done) state_next = ST_READY;
            end
            ST_READY: cart_ready = 1'b1;
            ST_ERROR: load_error = 1'b1;
            default:  state_next = ST_RESTART;
        endcase
        if (reload) state_next = ST_RESTART;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            index_q    <= index;
            word_ctr   <= '0;
            checksum   <= '0;
            flags_out  <= '0;
            settle_ctr <= '0;
            mem_wren   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_mask   <= '0;
        end else begin
            mem_wren   <= 1'b0;
            settle_ctr <= (state == ST_SETTLE) ? settle_ctr + 1'b1 : '0;
            if (reload) begin
                index_q   <= index;
                word_ctr  <= '0;
                checksum  <= '0;
                flags_out <= '0;
            end else if (accept) begin
                case (role)
                    ROLE_IMAGE: begin
                        mem_wren  <= 1'b1;
                        mem_addr  <= word_ctr[ADDR_W-1:0];
                        mem_wdata <= fl_rdata;
                        mem_mask  <= 4'b1111;
                        checksum  <= checksum + fl_rdata;
                        word_ctr  <= word_ctr + 1'b1;
                    end
                    ROLE_FLAGS: begin
                        flags_out <= fl_rdata;
                        if (CHECK_EN != 0) word_ctr <= word_ctr + 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cart_loader.sv
// Bench for cart_loader: a flash responder driven from tasks, a write monitor,
// and a slot-level reference model (addresses, wrapping sum, expected outcome).
module tb_cart_loader;

    localparam int IW = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        reload_a, fl_ready_a, fl_valid_a, mem_wren_a;
    logic        busy_a, cart_ready_a, load_error_a;
    logic [3:0]  index_a, mem_mask_a;
    logic [23:0] fl_addr_a;
    logic [1:0]  mem_addr_a;
    logic [31:0] fl_rdata_a, mem_wdata_a, flags_out_a;

    logic        reload_b, fl_ready_b, fl_valid_b, mem_wren_b;
    logic        busy_b, cart_ready_b, load_error_b;
    logic [3:0]  index_b, mem_mask_b;
    logic [23:0] fl_addr_b;
    logic [1:0]  mem_addr_b;
    logic [31:0] fl_rdata_b, mem_wdata_b, flags_out_b;

    cart_loader #(.IMAGE_WORDS(IW), .SETTLE_CYCLES(3), .CHECK_EN(1)) dut_a (
        .clock(clock), .reset(reset), .reload(reload_a), .index(index_a),
        .fl_valid(fl_valid_a), .fl_addr(fl_addr_a), .fl_ready(fl_ready_a), .fl_rdata(fl_rdata_a),
        .mem_wren(mem_wren_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_mask(mem_mask_a),
        .busy(busy_a), .cart_ready(cart_ready_a), .load_error(load_error_a), .flags_out(flags_out_a)
    );

    cart_loader #(.IMAGE_WORDS(IW), .SETTLE_CYCLES(0), .CHECK_EN(0)) dut_b (
        .clock(clock), .reset(reset), .reload(reload_b), .index(index_b),
        .fl_valid(fl_valid_b), .fl_addr(fl_addr_b), .fl_ready(fl_ready_b), .fl_rdata(fl_rdata_b),
        .mem_wren(mem_wren_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_mask(mem_mask_b),
        .busy(busy_b), .cart_ready(cart_ready_b), .load_error(load_error_b), .flags_out(flags_out_b)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } wr_t;

    typedef struct {
        logic [3:0]  idx;
        logic [23:0] first_addr;
    } addr_vec_t;

    wr_t         wq_a[$];
    int          wcnt_b = 0;
    int          wbase;
    logic [31:0] flash_img [16][IW+2];
    int          n_checks = 0;
    int          n_pass = 0;

    always @(posedge clock) begin
        #1;
        if (mem_wren_a) wq_a.push_back('{32'(mem_addr_a), mem_wdata_a, mem_mask_a});
        if (mem_wren_b) wcnt_b++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [23:0] exp_addr(input int slot, input int w);
        logic [31:0] a;
        a = 32'h100000 + 32'(slot) * 32'h40000 + 32'(w) * 32'd4;
        return a[23:0];
    endfunction

    function automatic logic [31:0] img_sum(input int slot);
        logic [31:0] s;
        s = '0;
        for (int w = 0; w < IW; w++) s += flash_img[slot][w];
        return s;
    endfunction

    task automatic fill_slot(input int slot, input bit corrupt);
        for (int w = 0; w < IW + 1; w++) flash_img[slot][w] = $urandom;
        flash_img[slot][IW+1] = corrupt ? (img_sum(slot) ^ (32'd1 << $urandom_range(31, 0)))
                                        : img_sum(slot);
    endtask

    task automatic start_load_a(input logic [3:0] slot);
        @(negedge clock);
        reload_a   = 1'b1;
        index_a    = slot;
        fl_ready_a = 1'b0;
        @(negedge clock);
        reload_a = 1'b0;
        index_a  = ~slot;
        wbase    = wq_a.size();
    endtask

    // Answers flash requests for one slot until fl_valid drops; optionally
    // fires reload together with the answer to word abort_word and returns.
    task automatic serve_a(input int slot, input int lat, input int abort_word,
                           input logic [3:0] new_slot,
                           output int nreq, output bit addr_ok, output bit timeout);
        int wait_n;
        bit seen;
        wait_n = 0; seen = 0; nreq = 0; addr_ok = 1; timeout = 1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clock);
            fl_ready_a = 1'b0;
            if (fl_valid_a) begin
                seen = 1;
                if (nreq > IW + 1 || fl_addr_a !== exp_addr(slot, nreq)) addr_ok = 0;
                if (wait_n < lat) begin
                    wait_n++;
                end else begin
                    wait_n     = 0;
                    fl_ready_a = 1'b1;
                    fl_rdata_a = flash_img[slot][(nreq > IW + 1) ? IW + 1 : nreq];
                    if (nreq == abort_word) begin
                        reload_a = 1'b1;
                        index_a  = new_slot;
                        timeout  = 0;
                        return;
                    end
                    nreq++;
                end
            end else if (seen) begin
                timeout = 0;
                return;
            end
        end
    endtask

    task automatic finish_load_a(input int slot, input int lat, input string tag);
        int nreq, d;
        bit addr_ok, timeout;
        serve_a(slot, lat, -1, 4'd0, nreq, addr_ok, timeout);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_fl_addr"}, addr_ok, 1);
        check({tag, "_requests"}, nreq, IW + 2);
        if (flash_img[slot][IW+1] == img_sum(slot)) begin
            check({tag, "_settle_busy"}, busy_a, 1);
            check({tag, "_settle_not_ready"}, cart_ready_a, 0);
            d = 0;
            while (!cart_ready_a && d < 400) begin
                @(negedge clock);
                d++;
            end
            check({tag, "_settle_cycles"}, d, 3);
            check({tag, "_ready_busy"}, busy_a, 0);
            check({tag, "_ready_error"}, load_error_a, 0);
        end else begin
            check({tag, "_error"}, load_error_a, 1);
            check({tag, "_error_ready"}, cart_ready_a, 0);
            check({tag, "_error_busy"}, busy_a, 0);
            check({tag, "_error_fl_valid"}, fl_valid_a, 0);
        end
        check({tag, "_flags"}, flags_out_a, flash_img[slot][IW]);
        check({tag, "_write_count"}, wq_a.size() - wbase, IW);
        for (int i = 0; i < IW; i++) begin
            if (wbase + i < wq_a.size()) begin
                check($sformatf("%s_waddr%0d", tag, i), wq_a[wbase+i].addr, i);
                check($sformatf("%s_wdata%0d", tag, i), wq_a[wbase+i].data, flash_img[slot][i]);
                check($sformatf("%s_wmask%0d", tag, i), wq_a[wbase+i].mask, 4'b1111);
            end
        end
    endtask

    initial begin
        addr_vec_t avec [4];
        int nreq, slot, ns, aw, nb, wb0, nwr;
        bit ok, to, seenb;
        logic [31:0] scen1 [IW+2];

        avec[0] = '{4'd0,  24'h100000};
        avec[1] = '{4'd2,  24'h180000};
        avec[2] = '{4'd7,  24'h2C0000};
        avec[3] = '{4'd15, 24'h4C0000};
        scen1   = '{32'd1, 32'd2, 32'd3, 32'd4, 32'hA5, 32'd10};

        reset = 1'b1;
        reload_a = 1'b0; fl_ready_a = 1'b0; index_a = 4'd3; fl_rdata_a = '0;
        reload_b = 1'b0; fl_ready_b = 1'b0; index_b = 4'd1; fl_rdata_b = '0;
        for (int s = 0; s < 16; s++) fill_slot(s, 1'b0);
        repeat (3) @(negedge clock);

        check("rst_busy", busy_a, 1);
        check("rst_fl_valid", fl_valid_a, 0);
        check("rst_cart_ready", cart_ready_a, 0);
        check("rst_load_error", load_error_a, 0);
        check("rst_flags", flags_out_a, 0);
        check("rst_mem_wren", mem_wren_a, 0);
        check("rst_mem_addr", mem_addr_a, 0);
        check("rst_mem_wdata", mem_wdata_a, 0);
        check("rst_mem_mask", mem_mask_a, 0);

        // Index is taken during reset; later changes must not affect the load.
        reset = 1'b0;
        index_a = 4'd9;
        index_b = 4'd4;
        wbase = wq_a.size();
        finish_load_a(3, 1, "post_reset");

        // No checksum word, zero settle: IW+1 requests and READY one cycle after SETTLE.
        nb = 0; seenb = 0; ok = 1; wb0 = wcnt_b;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clock);
            fl_ready_b = 1'b0;
            if (fl_valid_b) begin
                seenb = 1;
                if (nb > IW || fl_addr_b !== exp_addr(1, nb)) ok = 0;
                fl_ready_b = 1'b1;
                fl_rdata_b = flash_img[1][(nb > IW) ? IW : nb];
                nb++;
            end else if (seenb) begin
                break;
            end
        end
        check("nock_requests", nb, IW + 1);
        check("nock_fl_addr", ok, 1);
        check("nock_settle_busy", busy_b, 1);
        check("nock_settle_not_ready", cart_ready_b, 0);
        @(negedge clock);
        check("nock_ready", cart_ready_b, 1);
        check("nock_ready_busy", busy_b, 0);
        check("nock_error", load_error_b, 0);
        check("nock_flags", flags_out_b, flash_img[1][IW]);
        check("nock_writes", wcnt_b - wb0, IW);

        // Slot address table: one RESTART cycle, then the first request address.
        for (int i = 0; i < 4; i++) begin
            start_load_a(avec[i].idx);
            check($sformatf("vec%0d_restart_fl_valid", i), fl_valid_a, 0);
            check($sformatf("vec%0d_restart_busy", i), busy_a, 1);
            check($sformatf("vec%0d_restart_flags", i), flags_out_a, 0);
            @(negedge clock);
            check($sformatf("vec%0d_load_fl_valid", i), fl_valid_a, 1);
            check($sformatf("vec%0d_first_addr", i), fl_addr_a, avec[i].first_addr);
        end

        // Known image with a matching checksum.
        for (int w = 0; w < IW + 2; w++) flash_img[2][w] = scen1[w];
        start_load_a(4'd2);
        finish_load_a(2, 0, "s1");

        // A read completion while READY is ignored.
        @(negedge clock);
        nwr = wq_a.size();
        fl_ready_a = 1'b1;
        fl_rdata_a = 32'hDEADBEEF;
        @(negedge clock);
        fl_ready_a = 1'b0;
        check("idle_ready_no_write", mem_wren_a, 0);
        check("idle_ready_flags", flags_out_a, 32'hA5);
        check("idle_ready_state", cart_ready_a, 1);
        @(negedge clock);
        check("idle_ready_write_count", wq_a.size(), nwr);

        // Wrong checksum.
        flash_img[2][IW+1] = 32'd11;
        start_load_a(4'd2);
        finish_load_a(2, 1, "s2");
        repeat (4) @(negedge clock);
        check("s2_error_held", load_error_a, 1);
        check("s2_fl_valid_held", fl_valid_a, 0);
        check("s2_flags_held", flags_out_a, 32'hA5);

        // reload together with fl_ready on word 2 switches to slot 5.
        flash_img[2][IW+1] = 32'd10;
        start_load_a(4'd2);
        serve_a(2, 1, 2, 4'd5, nreq, ok, to);
        check("s3_abort_reached", to, 0);
        @(negedge clock);
        reload_a = 1'b0;
        fl_ready_a = 1'b0;
        check("s3_no_write", mem_wren_a, 0);
        check("s3_restart_fl_valid", fl_valid_a, 0);
        check("s3_restart_busy", busy_a, 1);
        check("s3_restart_flags", flags_out_a, 0);
        check("s3_writes_before_abort", wq_a.size() - wbase, 2);
        wbase = wq_a.size();
        @(negedge clock);
        check("s3_refetch_addr", fl_addr_a, exp_addr(5, 0));
        finish_load_a(5, 0, "s3");

        // Randomized loads, some corrupted, some aborted by reload mid-transfer.
        for (int r = 0; r < 16; r++) begin
            slot = $urandom_range(15, 0);
            fill_slot(slot, $urandom_range(3, 0) == 0);
            start_load_a(4'(slot));
            if ($urandom_range(3, 0) == 0) begin
                aw = $urandom_range(IW + 1, 0);
                ns = $urandom_range(15, 0);
                fill_slot(ns, 1'b0);
                serve_a(slot, $urandom_range(2, 0), aw, 4'(ns), nreq, ok, to);
                check($sformatf("rnd%0d_abort_reached", r), to, 0);
                check($sformatf("rnd%0d_abort_addr", r), ok, 1);
                @(negedge clock);
                reload_a = 1'b0;
                fl_ready_a = 1'b0;
                check($sformatf("rnd%0d_abort_writes", r), wq_a.size() - wbase, (aw < IW) ? aw : IW);
                wbase = wq_a.size();
                slot = ns;
            end
            finish_load_a(slot, $urandom_range(2, 0), $sformatf("rnd%0d", r));
        end

        // Reset mid-load with a read completing in the same cycle.
        start_load_a(4'd4);
        @(negedge clock);
        fl_ready_a = 1'b1;
        fl_rdata_a = flash_img[4][0];
        @(negedge clock);
        fl_ready_a = 1'b1;
        fl_rdata_a = flash_img[4][1];
        reset = 1'b1;
        index_a = 4'd6;
        @(negedge clock);
        check("s6_mem_wren", mem_wren_a, 0);
        check("s6_fl_valid", fl_valid_a, 0);
        check("s6_busy", busy_a, 1);
        check("s6_cart_ready", cart_ready_a, 0);
        check("s6_load_error", load_error_a, 0);
        check("s6_flags", flags_out_a, 0);
        check("s6_mem_addr", mem_addr_a, 0);
        check("s6_mem_wdata", mem_wdata_a, 0);
        check("s6_mem_mask", mem_mask_a, 0);
        reset = 1'b0;
        fl_ready_a = 1'b0;
        index_a = 4'd11;
        wbase = wq_a.size();
        finish_load_a(6, 2, "s6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
